phase_corr_peak_finder: RTL and testbench

Scans the real part of the 32×32 phase-correlation surface produced by the inverse-FFT stage and reports the location of its maximum as a signed motion vector (dx, dy). It sits directly downstream of the phase-correlation / inverse-FFT block, which streams one surface sample per accepted cycle. The block converts the argmax index to a wrapped (FFT-shifted) displacement and presents it, with the peak value, to the motion-vector consumer.

---
 rtl/phase_corr_pkg.sv | 19 +
 rtl/phase_corr_peak_finder.sv | 90 +++++++++
 tb/tb_phase_corr_peak_finder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/phase_corr_pkg.sv
// rtl/phase_corr_pkg.sv - shared sizes, types and index wrap helper for the phase-correlation peak path
package phase_corr_pkg;

  localparam int DIM   = 32;
  localparam int W     = 16;
  localparam int IDX_W = $clog2(DIM);

  typedef logic signed [W-1:0]     sample_t;
  typedef logic        [IDX_W-1:0] idx_t;
  typedef logic signed [IDX_W-1:0] disp_t;

  typedef enum logic {ACCEPT, REPORT} state_t;

  // With DIM a power of two, reading the index as two's complement is exactly i - DIM for i >= DIM/2.
  function automatic disp_t wrap_idx(input idx_t i);
    return $signed(i);
  endfunction

endpackage

// File: rtl/phase_corr_peak_finder.sv
// rtl/phase_corr_peak_finder.sv - argmax of a DIMxDIM correlation surface, reported as a wrapped motion vector
module phase_corr_peak_finder #(
  parameter int DIM = phase_corr_pkg::DIM,
  parameter int W   = phase_corr_pkg::W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [W-1:0]            s_data,
  output logic                    mv_valid,
  output logic [$clog2(DIM)-1:0]  mv_dx,
  output logic [$clog2(DIM)-1:0]  mv_dy,
  output logic [W-1:0]            peak_val
);

  localparam int IW = $clog2(DIM);
  localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  phase_corr_pkg::state_t state, state_next;

  logic [IW-1:0]        row, col, max_row, max_col;
  logic signed [W-1:0]  max_val;
  logic                 accept, last, better;
  logic signed [W-1:0]  sel_val;
  logic [IW-1:0]        sel_row, sel_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= phase_corr_pkg::ACCEPT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    case (state)
      phase_corr_pkg::ACCEPT: begin
        s_ready = 1'b1;
        if (s_valid && last) state_next = phase_corr_pkg::REPORT;
      end
      phase_corr_pkg::REPORT: state_next = phase_corr_pkg::ACCEPT;
      default:                state_next = phase_corr_pkg::ACCEPT;
    endcase
  end

  assign accept = s_valid && s_ready;
  assign last   = (&row) && (&col);
  // Strictly greater so that ties keep the earliest sample.
  assign better  = $signed(s_data) > max_val;
  assign sel_val = better ? $signed(s_data) : max_val;
  assign sel_row = better ? row : max_row;
  assign sel_col = better ? col : max_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row      <= '0;
      col      <= '0;
      max_row  <= '0;
      max_col  <= '0;
      max_val  <= MIN_VAL;
      mv_valid <= 1'b0;
      mv_dx    <= '0;
      mv_dy    <= '0;
      peak_val <= '0;
    end else begin
      mv_valid <= 1'b0;
      if (accept) begin
        if (last) begin
          // Final sample folds into the result directly; running state restarts for the next frame.
          mv_valid <= 1'b1;
          mv_dx    <= phase_corr_pkg::wrap_idx(sel_col);
          mv_dy    <= phase_corr_pkg::wrap_idx(sel_row);
          peak_val <= sel_val;
          row      <= '0;
          col      <= '0;
          max_row  <= '0;
          max_col  <= '0;
          max_val  <= MIN_VAL;
        end else begin
          col     <= col + 1'b1;
          if (&col) row <= row + 1'b1;
          max_val <= sel_val;
          max_row <= sel_row;
          max_col <= sel_col;
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_corr_peak_finder.sv
// tb/tb_phase_corr_peak_finder.sv - table-driven scoreboard bench for the correlation peak finder
module tb_phase_corr_peak_finder;

  localparam int DIM = 32;
  localparam int W   = 16;
  localparam int N   = DIM * DIM;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [W-1:0]     s_data;
  logic             mv_valid;
  logic [4:0]       mv_dx, mv_dy;
  logic [W-1:0]     peak_val;

  phase_corr_peak_finder #(.DIM(DIM), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .mv_valid (mv_valid),
    .mv_dx    (mv_dx),
    .mv_dy    (mv_dy),
    .peak_val (peak_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    int base; bit noise;
    int k1; int v1; int k2; int v2;
    int dx; int dy; int pk;
  } frame_t;

  typedef struct { int dx; int dy; int pk; } exp_t;

  exp_t   exp_q[$];
  frame_t tbl[6];
  int     vectors = 0;
  int     miscompares = 0;
  int     pulses = 0;
  int     held_dx = 0, held_dy = 0, held_pk = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sample_val(input frame_t f, input int k);
    int v;
    v = f.base;
    if (f.noise) v = v + int'($urandom_range(0, 100)) - 50;
    if (k == f.k1) v = f.v1;
    if (k == f.k2) v = f.v2;
    return v;
  endfunction

  task automatic send_frame(input frame_t f, input int gap_pct, input int nsamp, input bit push);
    int k = 0;
    int cur_k = -1;
    int budget = 0;
    int v = 0;
    if (push) exp_q.push_back('{f.dx, f.dy, f.pk});
    while (k < nsamp) begin
      @(negedge clk);
      budget++;
      if (budget > 20000) begin
        chk("send_timeout", k, nsamp);
        s_valid = 1'b0;
        return;
      end
      if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        s_valid = 1'b0;
      end else begin
        if (cur_k != k) begin
          v     = sample_val(f, k);
          cur_k = k;
        end
        s_data  = v[W-1:0];
        s_valid = 1'b1;
        if (s_ready) begin
          @(posedge clk);
          k++;
        end
      end
    end
    #1 s_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_mv_valid", int'(mv_valid), 0);
      chk("rst_mv_dx", int'($signed(mv_dx)), 0);
      chk("rst_mv_dy", int'($signed(mv_dy)), 0);
      chk("rst_peak_val", int'($signed(peak_val)), 0);
      held_dx = 0; held_dy = 0; held_pk = 0;
    end else if (mv_valid) begin
      exp_t e;
      pulses++;
      chk("report_s_ready", int'(s_ready), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("mv_dx", int'($signed(mv_dx)), e.dx);
        chk("mv_dy", int'($signed(mv_dy)), e.dy);
        chk("peak_val", int'($signed(peak_val)), e.pk);
        held_dx = e.dx; held_dy = e.dy; held_pk = e.pk;
      end
    end else begin
      chk("accept_s_ready", int'(s_ready), 1);
      chk("hold_mv_dx", int'($signed(mv_dx)), held_dx);
      chk("hold_mv_dy", int'($signed(mv_dy)), held_dy);
      chk("hold_peak_val", int'($signed(peak_val)), held_pk);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, pulses %0d expected 10", pulses);
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;

    tbl[0] = '{0,      1'b0, 2*32+3,  500,  -1,  0,   3,   2,  500};
    tbl[1] = '{0,      1'b0, 31*32+16, 1000, -1, 0,  -16, -1,  1000};
    tbl[2] = '{0,      1'b0, 15*32+15, 1000, -1, 0,   15,  15, 1000};
    tbl[3] = '{0,      1'b0, 10,       200,  700, 200, 10,  0,  200};
    tbl[4] = '{-100,   1'b0, 1023,     -5,   -1, 0,  -1,  -1,  -5};
    tbl[5] = '{-32768, 1'b0, -1,       0,    -1, 0,   0,   0,  -32768};

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 6; i++) send_frame(tbl[i], 0, N, 1'b1);

    // Reset landing in the REPORT cycle must drop mv_valid without waiting for a clock.
    send_frame(tbl[0], 0, N, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("report_rst_mv_valid", int'(mv_valid), 0);
    chk("report_rst_peak_val", int'($signed(peak_val)), 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Gapped stream, then two frames back to back so the second waits out the REPORT bubble.
    f = '{0, 1'b1, 1*32+1, 700, -1, 0, 1, 1, 700};
    send_frame(f, 30, N, 1'b1);
    f = '{0, 1'b1, 30*32+2, 800, -1, 0, 2, -2, 800};
    send_frame(f, 0, N, 1'b1);
    repeat (3) @(negedge clk);

    // Partial frame with a large peak is discarded by a mid-frame reset.
    f = '{0, 1'b1, 100, 900, -1, 0, 0, 0, 0};
    send_frame(f, 10, 500, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    f = '{0, 1'b1, 4*32+5, 300, -1, 0, 5, 4, 300};
    send_frame(f, 0, N, 1'b1);
    repeat (4) @(negedge clk);

    chk("pulse_count", pulses, 10);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
